ecc_stream_codec: RTL and testbench

//  Parametrised, pipelined extended-Hamming (SEC-DED) codec with valid/ready streaming in place of APB register polling.

---
 rtl/ecc_stream_codec.sv | 193 +++++++++++++++++++
 tb/tb_ecc_stream_codec.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_stream_codec.sv
// Two-stage SEC-DED (extended Hamming) codec with valid/ready streaming and per-word mode.
// Stage 1 encodes / injects noise / passes the codeword; stage 2 decodes and drives the outputs.
module ecc_stream_codec #(
  parameter int DATA_BITS = 26,
  parameter int CNT_WIDTH = 16,
  localparam int PAR_BITS = (DATA_BITS <= 4)   ? 3 :
                            (DATA_BITS <= 11)  ? 4 :
                            (DATA_BITS <= 26)  ? 5 :
                            (DATA_BITS <= 57)  ? 6 :
                            (DATA_BITS <= 120) ? 7 : 8,
  localparam int CW_BITS  = DATA_BITS + PAR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [CW_BITS-1:0]   in_data,
  input  logic [CW_BITS-1:0]   in_noise,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW_BITS-1:0]   out_data,
  output logic [1:0]           out_err,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] cnt_corr,
  output logic [CNT_WIDTH-1:0] cnt_uncorr
);

  function automatic logic [CW_BITS-1:0] hamming_encode(input logic [DATA_BITS-1:0] d);
    logic [CW_BITS-1:0] cw;
    logic               p;
    int                 k;
    cw = '0;
    k  = 0;
    for (int i = 1; i < CW_BITS; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < PAR_BITS; j++) begin
      p = 1'b0;
      for (int i = 1; i < CW_BITS; i++) begin
        if (i[j] && (i != (1 << j))) p ^= cw[i];
      end
      cw[1 << j] = p;
    end
    cw[0] = ^cw[CW_BITS-1:1];
    return cw;
  endfunction

  function automatic logic [PAR_BITS-1:0] syndrome(input logic [CW_BITS-1:0] cw);
    logic [PAR_BITS-1:0] s;
    s = '0;
    for (int i = 1; i < CW_BITS; i++) begin
      if (cw[i]) s ^= PAR_BITS'(i);
    end
    return s;
  endfunction

  function automatic logic [DATA_BITS-1:0] extract_payload(input logic [CW_BITS-1:0] cw);
    logic [DATA_BITS-1:0] d;
    int                   k;
    d = '0;
    k = 0;
    for (int i = 1; i < CW_BITS; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [1:0]           s1_mode_q, s1_mode_d;
  logic [CW_BITS-1:0]   s1_cw_q, s1_cw_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [CW_BITS-1:0]   out_data_q, out_data_d;
  logic [1:0]           out_err_q, out_err_d;
  logic [CNT_WIDTH-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_WIDTH-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic                 s2_adv;
  logic                 in_ready_int;
  logic                 out_fire;
  logic [CW_BITS-1:0]   enc_cw;
  logic [PAR_BITS-1:0]  syn;
  logic                 par_odd;
  logic [CW_BITS-1:0]   fixed_cw;
  logic [1:0]           dec_err;

  // Stage 1 may refill in the same cycle stage 2 drains, so there is no bubble.
  assign s2_adv       = !s2_valid_q || out_ready;
  assign in_ready_int = !s1_valid_q || s2_adv;
  assign out_fire     = s2_valid_q && out_ready;

  always_comb begin
    enc_cw     = hamming_encode(in_data[DATA_BITS-1:0]);
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_cw_d    = s1_cw_q;
    if (in_ready_int) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = in_mode;
        case (in_mode)
          2'b00:   s1_cw_d = enc_cw;
          2'b01:   s1_cw_d = in_data;
          2'b10:   s1_cw_d = enc_cw ^ in_noise;
          default: s1_cw_d = '0;
        endcase
      end
    end
  end

  always_comb begin
    syn      = syndrome(s1_cw_q);
    par_odd  = ^s1_cw_q;
    fixed_cw = s1_cw_q;
    dec_err  = 2'b10;
    if (!par_odd && syn == '0) begin
      dec_err = 2'b00;
    end else if (par_odd && int'(syn) < CW_BITS) begin
      dec_err = 2'b01;
      // syn == 0 means the flipped bit is the overall-parity bit, which carries no payload
      if (syn != '0) fixed_cw[syn] = ~s1_cw_q[syn];
    end

    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (s1_mode_q)
          2'b00: begin
            out_data_d = s1_cw_q;
            out_err_d  = 2'b00;
          end
          2'b01, 2'b10: begin
            out_data_d = CW_BITS'(extract_payload(fixed_cw));
            out_err_d  = dec_err;
          end
          default: begin
            out_data_d = '0;
            out_err_d  = 2'b11;
          end
        endcase
      end
    end

    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (stat_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_fire) begin
      if (out_err_q == 2'b01 && cnt_corr_q != '1)   cnt_corr_d   = cnt_corr_q + CNT_WIDTH'(1);
      if (out_err_q == 2'b10 && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 2'b00;
      s1_cw_q      <= '0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 2'b00;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_cw_q      <= s1_cw_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign in_ready   = in_ready_int;
  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_ecc_stream_codec.sv
// Scoreboard bench for ecc_stream_codec: a 4-bit/2-bit-counter instance for streaming, stalls,
// saturation and reset, and a 26-bit instance for exhaustive single and random double flips.
module tb_ecc_stream_codec;
  localparam int CA = 8;
  localparam int CB = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, stat_clr_a;
  logic [1:0]  in_mode_a, out_err_a, cnt_corr_a, cnt_uncorr_a;
  logic [7:0]  in_data_a, in_noise_a, out_data_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, stat_clr_b;
  logic [1:0]  in_mode_b, out_err_b;
  logic [31:0] in_data_b, in_noise_b, out_data_b;
  logic [15:0] cnt_corr_b, cnt_uncorr_b;

  ecc_stream_codec #(.DATA_BITS(4), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_mode(in_mode_a),
    .in_data(in_data_a), .in_noise(in_noise_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_err(out_err_a), .stat_clr(stat_clr_a),
    .cnt_corr(cnt_corr_a), .cnt_uncorr(cnt_uncorr_a));

  ecc_stream_codec #(.DATA_BITS(26), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_mode(in_mode_b),
    .in_data(in_data_b), .in_noise(in_noise_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_err(out_err_b), .stat_clr(stat_clr_b),
    .cnt_corr(cnt_corr_b), .cnt_uncorr(cnt_uncorr_b));

  int checks = 0;
  int errors = 0;
  logic [33:0] qa[$];
  logic [33:0] qb[$];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: place payload bits, then set parity bits so the XOR of set positions is 0.
  function automatic logic [31:0] ref_encode(input logic [31:0] payload, input int cw);
    logic [31:0] c;
    int d;
    int s;
    c = '0; d = 0; s = 0;
    for (int i = 1; i < cw; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (payload[d]) begin
          c[i] = 1'b1;
          s ^= i;
        end
        d++;
      end
    end
    for (int j = 0; (1 << j) < cw; j++) if (s[j]) c[1 << j] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] c, input int cw);
    logic [31:0] p;
    int d;
    p = '0; d = 0;
    for (int i = 1; i < cw; i++) begin
      if ((i & (i - 1)) != 0) begin
        p[d] = c[i];
        d++;
      end
    end
    return p;
  endfunction

  // Expected {err, data}: decided by how many bits the channel flipped, not by a syndrome.
  function automatic logic [33:0] exp_word(input logic [1:0] mode, input logic [31:0] payload,
                                           input logic [31:0] mask, input int cw);
    int n;
    n = $countones(mask);
    if (mode == 2'b00) return {2'b00, ref_encode(payload, cw)};
    if (mode == 2'b11) return {2'b11, 32'h0};
    if (n == 0) return {2'b00, payload};
    if (n == 1) return {2'b01, payload};
    return {2'b10, ref_extract(ref_encode(payload, cw) ^ mask, cw)};
  endfunction

  function automatic logic [31:0] flips(input int n, input int cw);
    logic [31:0] m;
    int p1;
    int p2;
    m = '0;
    p1 = int'($urandom_range(0, cw - 1));
    p2 = (p1 + int'($urandom_range(1, cw - 1))) % cw;
    if (n >= 1) m[p1] = 1'b1;
    if (n >= 2) m[p2] = 1'b1;
    return m;
  endfunction

  task automatic send_a(input logic [1:0] mode, input logic [31:0] payload, input logic [31:0] mask);
    logic [31:0] junk;
    int n;
    junk = $urandom;
    in_mode_a = mode;
    case (mode)
      2'b01: begin in_data_a = 8'(ref_encode(payload, CA) ^ mask); in_noise_a = junk[7:0]; end
      2'b10: begin in_data_a = {junk[7:4], payload[3:0]}; in_noise_a = mask[7:0]; end
      default: begin in_data_a = {junk[7:4], payload[3:0]}; in_noise_a = junk[15:8]; end
    endcase
    in_valid_a = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_a) begin
      n++;
      if (n > 2000) begin
        $display("FAIL send_a_timeout actual=in_ready_low required=in_ready_high");
        $fatal(1, "send_a timeout");
      end
      @(negedge clk);
    end
    qa.push_back(exp_word(mode, payload, mask, CA));
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] payload, input logic [31:0] mask);
    int n;
    in_mode_b  = 2'b01;
    in_data_b  = ref_encode(payload, CB) ^ mask;
    in_noise_b = $urandom;
    in_valid_b = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_b) begin
      n++;
      if (n > 2000) begin
        $display("FAIL send_b_timeout actual=in_ready_low required=in_ready_high");
        $fatal(1, "send_b timeout");
      end
      @(negedge clk);
    end
    qb.push_back(exp_word(2'b01, payload, mask, CB));
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input bit which_b);
    int n;
    n = 0;
    while (n < 2000 && (which_b ? (qb.size() != 0 || out_valid_b) : (qa.size() != 0 || out_valid_a))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
  endtask

  // Monitor A: pops on every output handshake, checks stall stability and counter model.
  logic [33:0] mon_e_a;
  logic [7:0]  held_d;
  logic [1:0]  held_e;
  bit          hold = 1'b0;
  int          corr_m = 0, unc_m = 0;
  always @(negedge clk) begin
    if (!rst) begin
      qa.delete();
      corr_m = 0; unc_m = 0; hold = 1'b0;
    end else begin
      check("cnt_corr_a", 64'(cnt_corr_a), 64'(corr_m));
      check("cnt_uncorr_a", 64'(cnt_uncorr_a), 64'(unc_m));
      if (hold) check("stall_stable_a", {out_valid_a, out_err_a, out_data_a}, {1'b1, held_e, held_d});
      hold = 1'b0;
      if (out_valid_a) begin
        if (out_ready_a) begin
          if (qa.size() == 0) begin
            check("unexpected_out_a", {out_err_a, out_data_a}, 64'hDEAD);
          end else begin
            mon_e_a = qa.pop_front();
            check("out_a", {out_err_a, out_data_a}, {mon_e_a[33:32], mon_e_a[7:0]});
            if (mon_e_a[33:32] == 2'b01 && corr_m < 3) corr_m++;
            if (mon_e_a[33:32] == 2'b10 && unc_m < 3) unc_m++;
          end
        end else begin
          hold = 1'b1; held_d = out_data_a; held_e = out_err_a;
        end
      end
      if (stat_clr_a) begin corr_m = 0; unc_m = 0; end
    end
  end

  logic [33:0] mon_e_b;
  int          corr_b_m = 0, unc_b_m = 0;
  always @(negedge clk) begin
    if (!rst) begin
      qb.delete();
    end else if (out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        check("unexpected_out_b", {out_err_b, out_data_b}, 64'hDEAD);
      end else begin
        mon_e_b = qb.pop_front();
        check("out_b", {out_err_b, out_data_b}, mon_e_b);
        if (mon_e_b[33:32] == 2'b01) corr_b_m++;
        if (mon_e_b[33:32] == 2'b10) unc_b_m++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready_a = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int seen;
    logic [31:0] pl;
    in_valid_a = 0; in_mode_a = 0; in_data_a = 0; in_noise_a = 0; out_ready_a = 1; stat_clr_a = 0;
    in_valid_b = 0; in_mode_b = 0; in_data_b = 0; in_noise_b = 0; out_ready_b = 1; stat_clr_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid_a), 64'(0));
    check("rst_out_data", 64'(out_data_a), 64'(0));
    check("rst_out_err", 64'(out_err_a), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready_a), 64'(1));
    check("rst_cnt", {cnt_corr_a, cnt_uncorr_a}, 64'(0));

    // Encode 4'hB -> 8'hAA, visible after the second edge following acceptance
    send_a(2'b00, 32'hB, 32'h0);
    check("latency_edge1_valid", 64'(out_valid_a), 64'(0));
    @(posedge clk); #1;
    check("latency_edge2_valid", 64'(out_valid_a), 64'(1));
    check("encode_B", {out_err_a, out_data_a}, {2'b00, 8'hAA});
    drain(1'b0);

    send_a(2'b01, 32'hB, 32'h20);
    drain(1'b0);
    check("cnt_corr_after_8A", 64'(cnt_corr_a), 64'(1));
    send_a(2'b01, 32'hB, 32'h01);
    send_a(2'b01, 32'hB, 32'h03);
    drain(1'b0);
    check("cnt_corr_2", 64'(cnt_corr_a), 64'(2));
    check("cnt_uncorr_A9", 64'(cnt_uncorr_a), 64'(1));
    send_a(2'b10, 32'hB, 32'h20);
    send_a(2'b11, 32'($urandom_range(0, 15)), 32'h0);
    send_a(2'b01, 32'h6, 32'h40);
    send_a(2'b10, 32'h9, 32'h04);
    drain(1'b0);
    check("cnt_corr_saturated", 64'(cnt_corr_a), 64'(3));
    check("cnt_uncorr_after_mode3", 64'(cnt_uncorr_a), 64'(1));

    // Clear coincident with a corrected-word handshake
    send_a(2'b01, 32'h5, 32'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stat_clr_a = 1'b1;
    @(posedge clk); #1;
    stat_clr_a = 1'b0;
    check("clr_wins_corr", 64'(cnt_corr_a), 64'(0));
    check("clr_wins_uncorr", 64'(cnt_uncorr_a), 64'(0));
    drain(1'b0);

    rand_ready = 1'b1;
    for (int w = 0; w < 100; w++)
      send_a(2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)), flips(int'($urandom_range(0, 2)), CA));
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    drain(1'b0);

    // Reset with two words in flight
    out_ready_a = 1'b0;
    send_a(2'b00, 32'h3, 32'h0);
    send_a(2'b00, 32'hC, 32'h0);
    check("two_in_flight", 64'(out_valid_a), 64'(1));
    #2 rst = 1'b0;
    #1 check("rst_mid_out_valid", 64'(out_valid_a), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready_a = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_a) seen++;
    end
    check("no_words_after_rst", 64'(seen), 64'(0));
    @(posedge clk); #1;

    // 26-bit instance: every single-bit flip corrected, random double flips detected
    for (int r = 0; r < 4; r++) begin
      pl = $urandom & 32'h03FF_FFFF;
      for (int b = 0; b < CB; b++) send_b(pl, 32'h1 << b);
    end
    for (int r = 0; r < 100; r++) send_b($urandom & 32'h03FF_FFFF, flips(2, CB));
    drain(1'b1);
    check("cnt_corr_b", 64'(cnt_corr_b), 64'(corr_b_m));
    check("cnt_uncorr_b", 64'(cnt_uncorr_b), 64'(unc_b_m));
    check("queues_empty", 64'(qa.size() + qb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
